// File: rtl/fifo_status.sv
// fifo_status: synchronous show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow.
// The head word is read combinationally at r_ptr, so r_data is valid in the same
// cycle that empty deasserts. All flags are decoded from the registered count.
module fifo_status #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Thresholds sized to the count so all comparisons are unsigned and width-matched.
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;

    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic unf_set;

    // Accept decisions: a write at full is allowed when a read frees a slot in the
    // same cycle; a read is only accepted when something is stored.
    always_comb begin
        wr_acc  = wr & (~full | rd);
        rd_acc  = rd & ~empty;
        ovf_set = wr & full & ~rd;
        unf_set = rd & empty;
    end

    // Status flags decoded from the registered count.
    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH_C);
        almost_empty = (count <= AEMPTY_C);
        almost_full  = (count >= AFULL_C);
    end

    // Show-ahead read port: the head word is always presented.
    assign r_data = mem[r_ptr];

    // Storage array; not cleared by reset, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_acc) begin
            mem[w_ptr] <= w_data;
        end
    end

    // Pointer, count and sticky-flag state. Flush discards contents but keeps the
    // error history; a set in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= overflow & ~clr_err;
            underflow <= underflow & ~clr_err;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
            count     <= count + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
            overflow  <= ovf_set | (overflow & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

endmodule
